// File: rtl/matvec_seq_ctrl_if.sv
// Avalon-style read-only memory port between the matrix-vector sequencer
// and mem_wrapper: one outstanding read, waitrequest stall, readdatavalid strobe.
interface matvec_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic [WORD_WIDTH-1:0] mem_readdata;
    logic                  mem_readdatavalid;
    logic                  mem_waitrequest;

    modport master (
        output mem_address,
        output mem_read,
        input  mem_readdata,
        input  mem_readdatavalid,
        input  mem_waitrequest
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        output mem_readdata,
        output mem_readdatavalid,
        output mem_waitrequest
    );
endinterface

// File: rtl/matvec_seq_ctrl.sv
// Matrix-vector sequencer: fetches the B row and NUM_ROWS A rows from memory,
// then accumulates NUM_ROWS dot products in parallel over VEC_LEN cycles.
module matvec_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    parameter int NUM_ROWS   = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    matvec_seq_ctrl_if.master             mem,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_ROWS*ACC_WIDTH-1:0] result,
    output logic [2:0]                    state_dbg
);
    localparam int WORD_WIDTH = DATA_WIDTH * VEC_LEN;
    localparam int ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int K_W        = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PROD_W     = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_B  = 3'd1,
        WAIT_B = 3'd2,
        REQ_A  = 3'd3,
        WAIT_A = 3'd4,
        EXEC   = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ROW_W-1:0]      row_idx;
    logic [K_W-1:0]        k;
    logic [WORD_WIDTH-1:0] b_row;
    logic [WORD_WIDTH-1:0] a_row [NUM_ROWS];
    logic [ACC_WIDTH-1:0]  acc   [NUM_ROWS];
    logic [PROD_W-1:0]     prod  [NUM_ROWS];

    logic start_ok;
    logic b_capture;
    logic a_capture;
    logic exec_step;
    logic last_row;
    logic last_k;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next      = state;
        mem.mem_read    = 1'b0;
        mem.mem_address = '0;
        start_ok        = 1'b0;
        b_capture       = 1'b0;
        a_capture       = 1'b0;
        exec_step       = 1'b0;
        last_row        = (row_idx == ROW_W'(NUM_ROWS - 1));
        last_k          = (k == K_W'(VEC_LEN - 1));

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = REQ_B;
                end
            end
            REQ_B: begin
                mem.mem_read    = 1'b1;
                mem.mem_address = base_q;
                if (!mem.mem_waitrequest) state_next = WAIT_B;
            end
            WAIT_B: begin
                if (mem.mem_readdatavalid) begin
                    b_capture  = 1'b1;
                    state_next = REQ_A;
                end
            end
            REQ_A: begin
                // A rows sit directly after the B row; the sum wraps at ADDR_WIDTH.
                mem.mem_read    = 1'b1;
                mem.mem_address = base_q + ADDR_WIDTH'(row_idx) + ADDR_WIDTH'(1);
                if (!mem.mem_waitrequest) state_next = WAIT_A;
            end
            WAIT_A: begin
                if (mem.mem_readdatavalid) begin
                    a_capture  = 1'b1;
                    state_next = last_row ? EXEC : REQ_A;
                end
            end
            EXEC: begin
                exec_step = 1'b1;
                if (last_k) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Element k of every A row times element k of B, zero-extended before the multiply.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            prod[r] = PROD_W'(a_row[r][k*DATA_WIDTH +: DATA_WIDTH])
                    * PROD_W'(b_row[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the row buffers are cleared on reset as well, not just the control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            row_idx <= '0;
            k       <= '0;
            b_row   <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                a_row[r] <= '0;
                acc[r]   <= '0;
            end
        end else begin
            if (start_ok) begin
                base_q  <= base_addr;
                row_idx <= '0;
                k       <= '0;
                for (int r = 0; r < NUM_ROWS; r++) acc[r] <= '0;
            end
            if (b_capture) b_row <= mem.mem_readdata;
            if (a_capture) begin
                a_row[row_idx] <= mem.mem_readdata;
                if (!last_row) row_idx <= row_idx + 1'b1;
            end
            if (exec_step) begin
                for (int r = 0; r < NUM_ROWS; r++) acc[r] <= acc[r] + ACC_WIDTH'(prod[r]);
                k <= last_k ? '0 : k + 1'b1;
            end
        end
    end

    always_comb begin
        result = '0;
        for (int r = 0; r < NUM_ROWS; r++) result[r*ACC_WIDTH +: ACC_WIDTH] = acc[r];
    end

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// Directed bench for matvec_seq_ctrl: a default instance and an ACC_WIDTH=16
// instance share one Avalon memory responder selected by sel.
`timescale 1ns/1ps
module tb_matvec_seq_ctrl;
    localparam int AW = 32;
    localparam int WW = 64;
    localparam int NR = 8;
    localparam int unsigned NOM_LANE [NR] = '{36, 72, 108, 144, 180, 216, 252, 288};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sel = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          start0, start1;
    logic          busy0, done0, busy1, done1;
    logic [2:0]    st0, st1;
    logic [NR*24-1:0] result0;
    logic [NR*16-1:0] result1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matvec_seq_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) mif0 ();
    matvec_seq_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) mif1 ();

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    matvec_seq_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0), .base_addr(base_addr), .mem(mif0.master),
        .busy(busy0), .done(done0), .result(result0), .state_dbg(st0)
    );

    matvec_seq_ctrl #(.ACC_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .mem(mif1.master),
        .busy(busy1), .done(done1), .result(result1), .state_dbg(st1)
    );

    // Memory responder: stalls wait_cycles per request, answers latency cycles after accept.
    logic [WW-1:0] mem [0:31];
    logic [WW-1:0] rdata = '0;
    logic          rdv = 1'b0;
    logic          wreq;
    logic          req_read;
    logic [AW-1:0] req_addr;
    int            wait_cycles = 0;
    int            latency = 1;
    int            stall_cnt = 0;
    int            accepts = 0;
    int            stall_viol = 0;
    logic          pending = 1'b0;
    int            lat_cnt = 0;
    logic [AW-1:0] pend_addr = '0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] addr_log [$];

    assign req_read = sel ? mif1.mem_read : mif0.mem_read;
    assign req_addr = sel ? mif1.mem_address : mif0.mem_address;
    assign wreq     = req_read && (stall_cnt < wait_cycles);
    assign mif0.mem_readdata      = rdata;
    assign mif1.mem_readdata      = rdata;
    assign mif0.mem_readdatavalid = rdv;
    assign mif1.mem_readdatavalid = rdv;
    assign mif0.mem_waitrequest   = wreq;
    assign mif1.mem_waitrequest   = wreq;

    always @(posedge clk) begin
        rdv <= 1'b0;
        if (prev_stall && !(req_read && req_addr == prev_addr)) stall_viol <= stall_viol + 1;
        prev_stall <= req_read && wreq;
        prev_addr  <= req_addr;
        if (req_read && wreq) begin
            stall_cnt <= stall_cnt + 1;
        end else if (req_read) begin
            stall_cnt <= 0;
            accepts   <= accepts + 1;
            addr_log.push_back(req_addr);
            if (latency <= 1) begin
                rdv   <= 1'b1;
                rdata <= mem[req_addr[4:0]];
            end else begin
                pending   <= 1'b1;
                lat_cnt   <= latency - 1;
                pend_addr <= req_addr;
            end
        end
        if (pending) begin
            if (lat_cnt == 1) begin
                rdv     <= 1'b1;
                rdata   <= mem[pend_addr[4:0]];
                pending <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    task automatic load_nominal();
        for (int k = 0; k < 8; k++) mem[0][k*8 +: 8] = 8'(k + 1);
        for (int r = 0; r < NR; r++) mem[1 + r] = {8{8'(r + 1)}};
    endtask

    // Pulses start for one edge and waits (bounded) for done of the selected instance.
    task automatic run_job(input logic [AW-1:0] base, output int edges);
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        while (!(sel ? done1 : done0) && edges < 5000) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, output bit ok);
        int n = 0;
        while (st0 !== s && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (st0 === s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (st0 !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", st0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done0); end
        checks++; if (mif0.mem_read !== 1'b0) begin failures++; $display("FAIL reset_read: got %b expected 0", mif0.mem_read); end
        checks++; if (mif0.mem_address !== '0) begin failures++; $display("FAIL reset_addr: got %h expected 0", mif0.mem_address); end
        checks++; if (result0 !== '0) begin failures++; $display("FAIL reset_result: got %h expected 0", result0); end
        checks++; if (result1 !== '0) begin failures++; $display("FAIL reset_result16: got %h expected 0", result1); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        int edges;
        int log_base = addr_log.size();
        int acc_base = accepts;
        load_nominal();
        run_job(32'h0, edges);
        checks++; if (edges != 27) begin failures++; $display("FAIL nom_latency: got %0d expected 27", edges); end
        checks++; if (done0 !== 1'b1 || busy0 !== 1'b0 || st0 !== 3'd6) begin failures++; $display("FAIL nom_status: got done=%b busy=%b st=%0d expected 1 0 6", done0, busy0, st0); end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (result0[r*24 +: 24] !== 24'(NOM_LANE[r])) begin failures++; $display("FAIL nom_lane%0d: got %0d expected %0d", r, result0[r*24 +: 24], NOM_LANE[r]); end
        end
        checks++; if (accepts - acc_base != 9) begin failures++; $display("FAIL nom_accepts: got %0d expected 9", accepts - acc_base); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (addr_log.size() <= log_base + i || addr_log[log_base + i] !== AW'(i)) begin failures++; $display("FAIL nom_addr%0d: expected %0d", i, i); end
        end
    endtask

    task automatic test_backpressure();
        int edges;
        int acc_base = accepts;
        int viol_base = stall_viol;
        wait_cycles = 3;
        latency = 4;
        run_job(32'h0, edges);
        // 3 stall + 1 accept + 4 latency per fetch, 9 fetches, plus start edge and EXEC
        checks++; if (edges != 81) begin failures++; $display("FAIL bp_latency: got %0d expected 81", edges); end
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL bp_done: got %b expected 1", done0); end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (result0[r*24 +: 24] !== 24'(NOM_LANE[r])) begin failures++; $display("FAIL bp_lane%0d: got %0d expected %0d", r, result0[r*24 +: 24], NOM_LANE[r]); end
        end
        checks++; if (accepts - acc_base != 9) begin failures++; $display("FAIL bp_accepts: got %0d expected 9", accepts - acc_base); end
        checks++; if (stall_viol != viol_base) begin failures++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol - viol_base); end
        wait_cycles = 0;
        latency = 1;
    endtask

    task automatic test_start_while_busy();
        bit ok_a, ok_e;
        int n = 0;
        int log_base = addr_log.size();
        base_addr = 32'h0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_state(3'd4, ok_a);
        base_addr = 32'h10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_state(3'd5, ok_e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done0 && n < 2000) begin @(posedge clk); #1; n++; end
        checks++; if (!(ok_a && ok_e)) begin failures++; $display("FAIL swb_reach: got wait_a=%0d exec=%0d expected 1 1", ok_a, ok_e); end
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL swb_done: got %b expected 1", done0); end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (result0[r*24 +: 24] !== 24'(NOM_LANE[r])) begin failures++; $display("FAIL swb_lane%0d: got %0d expected %0d", r, result0[r*24 +: 24], NOM_LANE[r]); end
        end
        checks++; if (addr_log.size() - log_base != 9) begin failures++; $display("FAIL swb_accepts: got %0d expected 9", addr_log.size() - log_base); end
        checks++; if (addr_log.size() < log_base + 9 || addr_log[log_base + 8] !== 32'd8) begin failures++; $display("FAIL swb_last_addr: expected 8"); end
        base_addr = 32'h0;
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        int edges;
        base_addr = 32'h0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_state(3'd5, ok);
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (!ok || result0 === '0) begin failures++; $display("FAIL rst_exec_partial: got %h expected nonzero partial sums", result0); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (st0 !== 3'd0) begin failures++; $display("FAIL rst_exec_state: got %0d expected 0", st0); end
        checks++; if (result0 !== '0) begin failures++; $display("FAIL rst_exec_result: got %h expected 0", result0); end
        checks++; if (done0 !== 1'b0 || busy0 !== 1'b0 || mif0.mem_read !== 1'b0) begin failures++; $display("FAIL rst_exec_status: got done=%b busy=%b read=%b expected 0 0 0", done0, busy0, mif0.mem_read); end
        rst = 1'b0;
        @(posedge clk); #1;
        run_job(32'h0, edges);
        checks++; if (edges != 27) begin failures++; $display("FAIL rst_exec_rerun_latency: got %0d expected 27", edges); end
        checks++; if (result0[0 +: 24] !== 24'd36) begin failures++; $display("FAIL rst_exec_lane0: got %0d expected 36", result0[0 +: 24]); end
        checks++; if (result0[7*24 +: 24] !== 24'd288) begin failures++; $display("FAIL rst_exec_lane7: got %0d expected 288", result0[7*24 +: 24]); end
    endtask

    task automatic test_restart();
        int edges;
        int log_base = addr_log.size();
        mem[16] = {8{8'd2}};
        for (int r = 0; r < NR; r++) mem[17 + r] = {8{8'd1}};
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL restart_from_done: got %b expected 1", done0); end
        run_job(32'h10, edges);
        checks++; if (edges != 27) begin failures++; $display("FAIL restart_latency: got %0d expected 27", edges); end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (result0[r*24 +: 24] !== 24'd16) begin failures++; $display("FAIL restart_lane%0d: got %0d expected 16", r, result0[r*24 +: 24]); end
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (addr_log.size() <= log_base + i || addr_log[log_base + i] !== AW'(16 + i)) begin failures++; $display("FAIL restart_addr%0d: expected %0d", i, 16 + i); end
        end
    endtask

    task automatic test_overflow();
        int edges;
        for (int a = 0; a < 9; a++) mem[a] = {8{8'hFF}};
        sel = 1'b1;
        run_job(32'h0, edges);
        checks++; if (done1 !== 1'b1 || edges != 27) begin failures++; $display("FAIL ovf_done: got done=%b edges=%0d expected 1 27", done1, edges); end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (result1[r*16 +: 16] !== 16'hF008) begin failures++; $display("FAIL ovf_lane%0d: got %h expected f008", r, result1[r*16 +: 16]); end
        end
        sel = 1'b0;
        checks++; if (st0 !== 3'd6 || result0[0 +: 24] !== 24'd16) begin failures++; $display("FAIL ovf_other_idle: got st=%0d lane0=%0d expected 6 16", st0, result0[0 +: 24]); end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = '0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_exec();
        test_restart();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
